// File: rtl/spi_counter_pkg.sv
// spi_counter_pkg: shared register codes, CTRL bit positions and SPI frame FSM states for spi_counter_bank
package spi_counter_pkg;
  localparam int CMD_BITS = 8;
  localparam logic [2:0] REG_CTRL  = 3'd0;
  localparam logic [2:0] REG_CMP   = 3'd1;
  localparam logic [2:0] REG_COUNT = 3'd2;
  localparam logic [2:0] REG_IRQ   = 3'd3;
  localparam int CTRL_EN   = 0;
  localparam int CTRL_CLR  = 1;
  localparam int CTRL_STOP = 2;
  localparam int CTRL_IRQ  = 3;
  typedef enum logic [1:0] {IDLE, CMD, DATA, DONE} state_e;
endpackage

// File: rtl/spi_counter_bank_if.sv
// spi_counter_bank_if: SPI pin bundle
//   sck, ss (active-low), mosi driven by the host (master); miso driven by the counter bank (slave)
interface spi_counter_bank_if;
  logic sck;
  logic ss;
  logic mosi;
  logic miso;
  modport master (output sck, output ss, output mosi, input miso);
  modport slave  (input sck, input ss, input mosi, output miso);
endinterface

// File: rtl/spi_slave_frame.sv
// spi_slave_frame: oversampled SPI mode-0 slave framing an 8-bit command plus WIDTH data bits
//   clk, rst        system clock, async active-high reset
//   spi             pin bundle (slave side); miso is 0 outside a frame
//   rdata_i         read data, loaded into the tx shifter while cmd_valid_o is high
//   cmd_o           command byte of the current frame
//   wdata_o         received data word
//   cmd_valid_o     one-cycle pulse the clk after the 8th sck rise
//   wr_commit_o     one-cycle pulse the clk after the WIDTH-th rise of a write frame
module spi_slave_frame
  import spi_counter_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic                clk,
  input  logic                rst,
  spi_counter_bank_if.slave   spi,
  input  logic [WIDTH-1:0]    rdata_i,
  output logic [CMD_BITS-1:0] cmd_o,
  output logic [WIDTH-1:0]    wdata_o,
  output logic                cmd_valid_o,
  output logic                wr_commit_o
);
  logic [1:0] sck_q, ss_q, mosi_q;
  logic sck_p_q, ss_p_q;
  state_e state_q;
  logic [5:0] bit_q;
  logic [CMD_BITS-1:0] cmd_q;
  logic [WIDTH-1:0] rx_q;
  logic [WIDTH:0] tx_q;
  logic cmd_valid_q, wr_commit_q;
  logic rise, fall;
  assign rise = sck_q[1] & ~sck_p_q;
  assign fall = ~sck_q[1] & sck_p_q;
  // tx_q carries one spare bit above the data so the first fall after the load exposes the MSB
  assign spi.miso = (state_q != IDLE) & tx_q[WIDTH];
  assign cmd_o = cmd_q;
  assign wdata_o = rx_q;
  assign cmd_valid_o = cmd_valid_q;
  assign wr_commit_o = wr_commit_q;
  // ss synchroniser resets to "low" so a select held low across reset is not seen as a new frame
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      sck_q <= '0;
      ss_q <= '0;
      mosi_q <= '0;
      sck_p_q <= 1'b0;
      ss_p_q <= 1'b0;
      state_q <= IDLE;
      bit_q <= '0;
      cmd_q <= '0;
      rx_q <= '0;
      tx_q <= '0;
      cmd_valid_q <= 1'b0;
      wr_commit_q <= 1'b0;
    end else begin
      sck_q <= {sck_q[0], spi.sck};
      ss_q <= {ss_q[0], spi.ss};
      mosi_q <= {mosi_q[0], spi.mosi};
      sck_p_q <= sck_q[1];
      ss_p_q <= ss_q[1];
      cmd_valid_q <= 1'b0;
      wr_commit_q <= 1'b0;
      if (cmd_valid_q) tx_q <= {1'b0, rdata_i};
      if (ss_q[1]) state_q <= IDLE;
      else if (state_q == IDLE) begin
        if (ss_p_q) begin
          state_q <= CMD;
          bit_q <= '0;
          tx_q <= '0;
        end
      end else if (state_q == CMD && rise) begin
        cmd_q <= {cmd_q[CMD_BITS-2:0], mosi_q[1]};
        bit_q <= bit_q + 6'd1;
        if (bit_q == 6'(CMD_BITS - 1)) begin
          state_q <= DATA;
          bit_q <= '0;
          cmd_valid_q <= 1'b1;
        end
      end else if (state_q == DATA && rise) begin
        rx_q <= {rx_q[WIDTH-2:0], mosi_q[1]};
        bit_q <= bit_q + 6'd1;
        if (bit_q == 6'(WIDTH - 1)) begin
          state_q <= DONE;
          wr_commit_q <= ~cmd_q[CMD_BITS-1];
        end
      end else if (state_q == DATA && fall) tx_q <= {tx_q[WIDTH-1:0], 1'b0};
    end
endmodule

// File: rtl/spi_counter_bank.sv
// spi_counter_bank: SPI-controlled bank of CHANNELS event counters with per-channel compare and match flags
//   clk, rst   system clock, async active-high reset
//   spi        SPI pin bundle (slave side)
//   inc        per-channel count events, one count per cycle high
//   match      registered count==cmp flags
//   irq        OR of sticky pending match-edge bits (only when SPI_COUNTER_IRQ_EN is defined)
module spi_counter_bank
  import spi_counter_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 4
) (
  input  logic                clk,
  input  logic                rst,
  spi_counter_bank_if.slave   spi,
  input  logic [CHANNELS-1:0] inc,
  output logic [CHANNELS-1:0] match
`ifdef SPI_COUNTER_IRQ_EN
  ,
  output logic                irq
`endif
);
`ifdef SPI_COUNTER_IRQ_EN
  localparam logic [WIDTH-1:0] CTRL_WMASK = WIDTH'(4'hf);
`else
  localparam logic [WIDTH-1:0] CTRL_WMASK = WIDTH'(4'h7);
`endif
  localparam logic [WIDTH-1:0] CLR_BIT = WIDTH'(1) << CTRL_CLR;
  logic [CMD_BITS-1:0] cmd;
  logic [WIDTH-1:0] wdata, rdata;
  logic cmd_valid, wr_commit;
  logic [WIDTH-1:0] ctrl_q [CHANNELS];
  logic [WIDTH-1:0] cmp_q [CHANNELS];
  logic [WIDTH-1:0] cnt_q [CHANNELS];
  logic [CHANNELS-1:0] match_q, hit, wr_sel, step;
  logic [2:0] reg_sel;
  logic [3:0] ch_sel;
  assign reg_sel = cmd[6:4];
  assign ch_sel = cmd[3:0];
  assign match = match_q;
  spi_slave_frame #(.WIDTH(WIDTH)) u_frame (
    .clk(clk),
    .rst(rst),
    .spi(spi),
    .rdata_i(rdata),
    .cmd_o(cmd),
    .wdata_o(wdata),
    .cmd_valid_o(cmd_valid),
    .wr_commit_o(wr_commit)
  );
  // stop mode compares against the live count so the counter halts exactly at cmp rather than one past it
  always_comb begin
    hit = '0;
    wr_sel = '0;
    step = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      hit[c] = cnt_q[c] == cmp_q[c];
      wr_sel[c] = wr_commit && ch_sel == 4'(c);
      step[c] = ctrl_q[c][CTRL_EN] & inc[c] & ~(ctrl_q[c][CTRL_STOP] & hit[c]);
    end
  end
`ifdef SPI_COUNTER_IRQ_EN
  logic [CHANNELS-1:0] pend_q, irq_en, pend_clr;
  assign irq = |pend_q;
  always_comb begin
    irq_en = '0;
    for (int c = 0; c < CHANNELS; c++) irq_en[c] = ctrl_q[c][CTRL_IRQ];
    pend_clr = (wr_commit && reg_sel == REG_IRQ) ? CHANNELS'(wdata) : '0;
  end
  // hit & ~match_q is the cycle in which match rises; set is OR-ed after the clear so it wins
  always_ff @(posedge clk or posedge rst)
    if (rst) pend_q <= '0;
    else pend_q <= (pend_q & ~pend_clr) | (hit & ~match_q & irq_en);
`endif
  // a channel outside the bank never matches ch_sel, so its reads stay 0
  always_comb begin
    rdata = '0;
    for (int c = 0; c < CHANNELS; c++)
      if (cmd_valid && ch_sel == 4'(c))
        rdata = reg_sel == REG_CTRL ? ctrl_q[c] : reg_sel == REG_CMP ? cmp_q[c] : reg_sel == REG_COUNT ? cnt_q[c] : '0;
`ifdef SPI_COUNTER_IRQ_EN
    if (cmd_valid && reg_sel == REG_IRQ) rdata = WIDTH'(pend_q);
`endif
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      match_q <= '1;
      for (int c = 0; c < CHANNELS; c++) begin
        ctrl_q[c] <= '0;
        cmp_q[c] <= '0;
        cnt_q[c] <= '0;
      end
    end else begin
      match_q <= hit;
      for (int c = 0; c < CHANNELS; c++) begin
        ctrl_q[c] <= (wr_sel[c] && reg_sel == REG_CTRL) ? wdata & CTRL_WMASK : ctrl_q[c] & ~CLR_BIT;
        cmp_q[c] <= (wr_sel[c] && reg_sel == REG_CMP) ? wdata : cmp_q[c];
        cnt_q[c] <= ctrl_q[c][CTRL_CLR] ? '0 :
                    (wr_sel[c] && reg_sel == REG_COUNT) ? wdata :
                    step[c] ? cnt_q[c] + 1'b1 : cnt_q[c];
      end
    end
endmodule

// File: tb/tb_spi_counter_bank.sv
// tb_spi_counter_bank: directed plus randomized SPI frames and inc bursts checked against an array-based model
module tb_spi_counter_bank;
  localparam int W = 8;
`ifdef SPI_COUNTER_IRQ_EN
  localparam int CMASK = 'hd;
`else
  localparam int CMASK = 'h5;
`endif
  logic clk = 1'b0;
  logic rst;
  logic [3:0] inc;
  logic [3:0] match;
`ifdef SPI_COUNTER_IRQ_EN
  logic irq;
`endif
  int checks = 0;
  int errors = 0;
  int cnt_m [4];
  int cmp_m [4];
  int ctrl_m [4];
  logic [W-1:0] r;
  spi_counter_bank_if ifc ();
  spi_counter_bank #(.WIDTH(W), .CHANNELS(4)) dut (
    .clk(clk),
    .rst(rst),
    .spi(ifc),
    .inc(inc),
    .match(match)
`ifdef SPI_COUNTER_IRQ_EN
    ,
    .irq(irq)
`endif
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s got %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic frame(input logic [7:0] c, input logic [W-1:0] d, input int nbits, output logic [W-1:0] rd);
    logic [15:0] sh;
    sh = {c, d};
    rd = '0;
    ifc.ss = 1'b0;
    #100;
    for (int i = 0; i < nbits; i++) begin
      ifc.mosi = sh[15-i];
      #50;
      if (i >= 8) rd = {rd[W-2:0], ifc.miso};
      ifc.sck = 1'b1;
      #50;
      ifc.sck = 1'b0;
    end
    #100;
    ifc.ss = 1'b1;
    #200;
  endtask
  task automatic wr(input int rg, input int ch, input int d);
    logic [W-1:0] dummy;
    frame({1'b0, 3'(rg), 4'(ch)}, W'(d), 16, dummy);
    if (ch < 4) begin
      if (rg == 0) begin
        ctrl_m[ch] = d & CMASK;
        if (d & 2) cnt_m[ch] = 0;
      end
      if (rg == 1) cmp_m[ch] = d & 'hff;
      if (rg == 2) cnt_m[ch] = d & 'hff;
    end
  endtask
  function automatic int exp_rd(input int rg, input int ch);
    if (ch >= 4) return 0;
    return rg == 0 ? ctrl_m[ch] : rg == 1 ? cmp_m[ch] : rg == 2 ? cnt_m[ch] : 0;
  endfunction
  task automatic rd_chk(input string tag, input int rg, input int ch, input int exp);
    logic [W-1:0] v;
    frame({1'b1, 3'(rg), 4'(ch)}, '0, 16, v);
    check(tag, 32'(v), exp);
  endtask
  task automatic do_inc(input logic [3:0] v);
    @(posedge clk) #1 inc = v;
    for (int c = 0; c < 4; c++)
      if (v[c] && (ctrl_m[c] & 1) && !((ctrl_m[c] & 4) && cnt_m[c] == cmp_m[c])) cnt_m[c] = (cnt_m[c] + 1) % 256;
    @(posedge clk) #1 inc = '0;
  endtask
  function automatic logic [3:0] exp_match();
    logic [3:0] m;
    for (int c = 0; c < 4; c++) m[c] = cnt_m[c] == cmp_m[c];
    return m;
  endfunction
  initial begin
    int op, rg, ch, d, k;
    rst = 1'b1;
    inc = '0;
    ifc.ss = 1'b1;
    ifc.sck = 1'b0;
    ifc.mosi = 1'b0;
    for (int c = 0; c < 4; c++) begin
      cnt_m[c] = 0;
      cmp_m[c] = 0;
      ctrl_m[c] = 0;
    end
    repeat (3) @(posedge clk);
    #1;
    check("reset_miso", 32'(ifc.miso), 0);
    check("reset_match", 32'(match), 'hf);
    rst = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    for (int c = 0; c < 4; c++) rd_chk($sformatf("reset_count%0d", c), 2, c, 0);
    check("idle_miso", 32'(ifc.miso), 0);
    wr(1, 2, 'h05);
    check("cmp_write_match", 32'(match[2]), 0);
    wr(0, 2, 'h01);
    repeat (4) do_inc(4'b0100);
    do_inc(4'b0100);
    check("match_latency_pre", 32'(match[2]), 0);
    @(posedge clk) #1;
    check("match_latency_post", 32'(match[2]), 1);
    rd_chk("count2", 2, 2, 'h05);
    rd_chk("ctrl2", 0, 2, 'h01);
    wr(0, 1, 'h01);
    wr(2, 1, 'hfe);
    repeat (3) do_inc(4'b0010);
    rd_chk("wrap", 2, 1, 'h01);
    wr(0, 1, 'h05);
    wr(1, 1, 'hff);
    wr(2, 1, 'hfe);
    repeat (3) do_inc(4'b0010);
    rd_chk("stop_hold", 2, 1, 'hff);
    check("stop_match", 32'(match), 32'(exp_match()));
    frame({1'b0, 3'd2, 4'd0}, 8'haa, 12, r);
    rd_chk("abort_unchanged", 2, 0, 0);
    wr(2, 0, 'h3c);
    rd_chk("after_abort", 2, 0, 'h3c);
    wr(0, 1, 'h03);
    rd_chk("clear_count", 2, 1, 0);
    rd_chk("clear_selfclr", 0, 1, 'h01);
    wr(1, 7, 'h55);
    rd_chk("ch7_read", 1, 7, 0);
    rd_chk("ch7_no_alias", 1, 3, exp_rd(1, 3));
`ifdef SPI_COUNTER_IRQ_EN
    wr(1, 0, 2);
    wr(2, 0, 0);
    wr(3, 0, 'hff);
    check("irq_idle", 32'(irq), 0);
    wr(0, 0, 'h09);
    repeat (2) do_inc(4'b0001);
    @(posedge clk) #1;
    check("irq_set", 32'(irq), 1);
    rd_chk("irq_pend", 3, 0, 'h01);
    wr(3, 0, 'h01);
    check("irq_clr", 32'(irq), 0);
`endif
    for (int n = 0; n < 40; n++) begin
      op = $urandom_range(0, 2);
      rg = $urandom_range(0, 7);
      ch = $urandom_range(0, 7);
      d = $urandom_range(0, 255);
`ifdef SPI_COUNTER_IRQ_EN
      if (rg == 3) rg = 5;
`endif
      if (op == 0) wr(rg, ch, d);
      else if (op == 1) rd_chk($sformatf("rand_rd r%0d c%0d", rg, ch), rg, ch, exp_rd(rg, ch));
      else begin
        k = $urandom_range(1, 6);
        for (int i = 0; i < k; i++) do_inc(4'($urandom));
        @(posedge clk) #1;
        check("rand_match", 32'(match), 32'(exp_match()));
      end
    end
    for (int c = 0; c < 4; c++) rd_chk($sformatf("final_count%0d", c), 2, c, exp_rd(2, c));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
